// File: rtl/ram_fill_responder.sv
`default_nettype none
// ============================================================================
// Module   : ram_fill_responder
// Purpose  : Slow-RAM responder for cache line fills: queued requests are
//            serviced in order with fixed wait states, then returned.
// Revision : 1.0 - initial release
// ============================================================================
module ram_fill_responder #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_write,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [DATA_W-1:0] resp_data,
    output logic              busy
);

    localparam int c_PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int c_MEM_WORDS = 1 << ADDR_W;

    localparam logic [3:0]         c_WAIT_LOAD = 4'(LATENCY - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST  = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Request queue
    logic              r_fifo_write [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data  [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    // Service engine
    state_t            r_state;
    logic [3:0]        r_wcnt;
    logic              r_work_write;
    logic [ADDR_W-1:0] r_work_addr;
    logic [DATA_W-1:0] r_work_data;
    logic              r_resp_valid;
    logic              r_resp_write;
    logic [ADDR_W-1:0] r_resp_addr;
    logic [DATA_W-1:0] r_resp_data;
    logic [DATA_W-1:0] r_mem [c_MEM_WORDS];

    logic               w_push;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_wptr_next;
    logic [c_PTR_W-1:0] w_rptr_next;

    // Ready depends only on the registered count; a pop never frees a slot early.
    assign req_ready   = (r_count < c_CNT_FULL);
    assign w_push      = req_valid && req_ready;
    assign w_pop       = (r_state == ST_IDLE) && (r_count != '0);
    assign w_wptr_next = (r_wptr == c_PTR_LAST) ? '0 : r_wptr + 1'b1;
    assign w_rptr_next = (r_rptr == c_PTR_LAST) ? '0 : r_rptr + 1'b1;

    assign resp_valid = r_resp_valid;
    assign resp_write = r_resp_write;
    assign resp_addr  = r_resp_addr;
    assign resp_data  = r_resp_data;
    assign busy       = (r_count != '0) || (r_state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_write[r_wptr] <= req_write;
            r_fifo_addr[r_wptr]  <= req_addr;
            r_fifo_data[r_wptr]  <= req_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_next;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_wcnt       <= '0;
            r_work_write <= 1'b0;
            r_work_addr  <= '0;
            r_work_data  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_write <= 1'b0;
            r_resp_addr  <= '0;
            r_resp_data  <= '0;
            for (int i = 0; i < c_MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_work_write <= r_fifo_write[r_rptr];
                        r_work_addr  <= r_fifo_addr[r_rptr];
                        r_work_data  <= r_fifo_data[r_rptr];
                        r_wcnt       <= c_WAIT_LOAD;
                        r_state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_wcnt != 4'd0) begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end else begin
                        // Response fields are only loaded here, so they hold through RESP.
                        if (r_work_write) begin
                            r_mem[r_work_addr] <= r_work_data;
                            r_resp_data        <= r_work_data;
                        end else begin
                            r_resp_data <= r_mem[r_work_addr];
                        end
                        r_resp_write <= r_work_write;
                        r_resp_addr  <= r_work_addr;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_fill_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_fill_responder
// Purpose  : Directed self-checking bench for ram_fill_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_fill_responder;

    typedef struct packed {
        logic        w;
        logic [4:0]  a;
        logic [7:0]  d;
        logic [31:0] ed;
    } rec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_write;
    logic [4:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid, resp_ready, resp_write;
    logic [4:0] resp_addr;
    logic [7:0] resp_data;
    logic       busy;

    logic       l1_req_valid, l1_req_ready;
    logic [4:0] l1_req_addr;
    logic       l1_resp_valid, l1_resp_write, l1_busy;
    logic [4:0] l1_resp_addr;
    logic [7:0] l1_resp_data;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_accepted = 0;
    rec_t rq[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    ram_fill_responder #(.ADDR_W(5), .DATA_W(8), .LATENCY(3), .FIFO_DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_addr(resp_addr), .resp_data(resp_data), .busy(busy)
    );

    ram_fill_responder #(.ADDR_W(5), .DATA_W(8), .LATENCY(1), .FIFO_DEPTH(2)) dut_l1 (
        .clock(clock), .reset(reset),
        .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_write(1'b0),
        .req_addr(l1_req_addr), .req_wdata(8'h00),
        .resp_valid(l1_resp_valid), .resp_ready(1'b1), .resp_write(l1_resp_write),
        .resp_addr(l1_resp_addr), .resp_data(l1_resp_data), .busy(l1_busy)
    );

    // Record every completed response handshake; ed is the edge it completes on.
    always @(negedge clock) begin
        rec_t r;
        if (reset && resp_valid && resp_ready) begin
            r.w  = resp_write;
            r.a  = resp_addr;
            r.d  = resp_data;
            r.ed = 32'(cyc + 1);
            rq.push_back(r);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic w, input logic [4:0] a, input logic [7:0] d, output int acc);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin
                acc = cyc + 1;
                n_accepted++;
                break;
            end
            tick();
        end
        n_checks++;
        if (acc < 0) begin
            n_fail++;
            $display("FAIL send_accept addr %h: req_ready got 0 required 1 within 100 cycles", a);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n);
        for (int i = 0; i < 300 && rq.size() < n; i++) tick();
        n_checks++;
        if (rq.size() < n) begin
            n_fail++;
            $display("FAIL resp_count: got %0d responses required %0d", rq.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b1;
        l1_req_valid = 1'b0; l1_req_addr = '0;
        #1;
        n_checks++;
        if ({req_ready, resp_valid, resp_write, resp_addr, resp_data, busy} !== {1'b1, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b rw=%b ra=%h rd=%h busy=%b required 1 0 0 00 00 0",
                     req_ready, resp_valid, resp_write, resp_addr, resp_data, busy);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_read_latency();
        int e0;
        int rise;
        rq.delete();
        send(1'b0, 5'h0A, 8'h00, e0);
        rise = -1;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) begin
                rise = cyc;
                break;
            end
            tick();
        end
        n_checks++;
        if (rise - e0 !== 4) begin
            n_fail++;
            $display("FAIL read_latency: got %0d cycles required 4", rise - e0);
        end
        n_checks++;
        if ({resp_write, resp_addr, resp_data} !== {1'b0, 5'h0A, 8'h00}) begin
            n_fail++;
            $display("FAIL read_fields: got w=%b a=%h d=%h required w=0 a=0a d=00", resp_write, resp_addr, resp_data);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_idle_after: got busy=%b rv=%b required 0 0", busy, resp_valid);
        end
    endtask

    task automatic test_write_read();
        int e;
        rq.delete();
        send(1'b1, 5'h13, 8'hA5, e);
        send(1'b0, 5'h13, 8'h00, e);
        wait_resp(2);
        if (rq.size() >= 2) begin
            n_checks++;
            if ({rq[0].w, rq[0].a, rq[0].d} !== {1'b1, 5'h13, 8'hA5}) begin
                n_fail++;
                $display("FAIL wr_first: got w=%b a=%h d=%h required w=1 a=13 d=a5", rq[0].w, rq[0].a, rq[0].d);
            end
            n_checks++;
            if ({rq[1].w, rq[1].a, rq[1].d} !== {1'b0, 5'h13, 8'hA5}) begin
                n_fail++;
                $display("FAIL wr_readback: got w=%b a=%h d=%h required w=0 a=13 d=a5", rq[1].w, rq[1].a, rq[1].d);
            end
            n_checks++;
            if (int'(rq[1].ed) - int'(rq[0].ed) !== 5) begin
                n_fail++;
                $display("FAIL wr_spacing: got %0d cycles required 5", int'(rq[1].ed) - int'(rq[0].ed));
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        rq.delete();
        resp_ready = 1'b0;
        n_accepted = 0;
        fork
            begin
                int acc;
                for (int i = 0; i < 4; i++) send(1'b1, 5'(8 + i), 8'(8'h21 + i), acc);
            end
            begin
                repeat (12) tick();
                n_checks++;
                if (req_ready !== 1'b0 || n_accepted !== 3) begin
                    n_fail++;
                    $display("FAIL bp_full: got req_ready=%b accepted=%0d required 0 and 3", req_ready, n_accepted);
                end
                n_checks++;
                if ({resp_valid, resp_write, resp_addr, resp_data, busy} !== {1'b1, 1'b1, 5'h08, 8'h21, 1'b1}) begin
                    n_fail++;
                    $display("FAIL bp_held: got rv=%b w=%b a=%h d=%h busy=%b required 1 1 08 21 1",
                             resp_valid, resp_write, resp_addr, resp_data, busy);
                end
                resp_ready = 1'b1;
            end
        join
        wait_resp(4);
        for (int i = 0; i < 4 && i < rq.size(); i++) begin
            n_checks++;
            if ({rq[i].a, rq[i].d} !== {5'(8 + i), 8'(8'h21 + i)}) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got a=%h d=%h required a=%h d=%h", i, rq[i].a, rq[i].d, 5'(8 + i), 8'(8'h21 + i));
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_fifo_wrap();
        int e;
        rq.delete();
        for (int i = 0; i < 6; i++) send(1'b1, 5'(i), 8'(8'h10 + i), e);
        for (int i = 0; i < 6; i++) send(1'b0, 5'(i), 8'h00, e);
        wait_resp(12);
        for (int i = 6; i < 12 && i < rq.size(); i++) begin
            n_checks++;
            if ({rq[i].w, rq[i].a, rq[i].d} !== {1'b0, 5'(i - 6), 8'(8'h10 + i - 6)}) begin
                n_fail++;
                $display("FAIL wrap_read[%0d]: got w=%b a=%h d=%h required w=0 a=%h d=%h",
                         i - 6, rq[i].w, rq[i].a, rq[i].d, 5'(i - 6), 8'(8'h10 + i - 6));
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        int e;
        rq.delete();
        send(1'b1, 5'h1F, 8'h3C, e);
        tick(); tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: got %b required 1", busy);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, resp_valid, resp_write, resp_addr, resp_data, busy} !== {1'b1, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got rdy=%b rv=%b rw=%b ra=%h rd=%h busy=%b required 1 0 0 00 00 0",
                     req_ready, resp_valid, resp_write, resp_addr, resp_data, busy);
        end
        tick(); tick();
        reset = 1'b1;
        repeat (10) tick();
        n_checks++;
        if (rq.size() !== 0) begin
            n_fail++;
            $display("FAIL mid_no_resp: got %0d responses required 0", rq.size());
        end
        send(1'b0, 5'h1F, 8'h00, e);
        send(1'b0, 5'h13, 8'h00, e);
        wait_resp(2);
        if (rq.size() >= 2) begin
            n_checks++;
            if (rq[0].d !== 8'h00) begin
                n_fail++;
                $display("FAIL mid_read_1f: got %h required 00", rq[0].d);
            end
            n_checks++;
            if (rq[1].d !== 8'h00) begin
                n_fail++;
                $display("FAIL mid_read_13_cleared: got %h required 00", rq[1].d);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_latency_one();
        int e0;
        int rise;
        l1_req_valid = 1'b1;
        l1_req_addr  = 5'h03;
        e0 = cyc + 1;
        n_checks++;
        if (l1_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL l1_ready: got %b required 1", l1_req_ready);
        end
        tick();
        l1_req_valid = 1'b0;
        rise = -1;
        for (int i = 0; i < 10; i++) begin
            if (l1_resp_valid) begin
                rise = cyc;
                break;
            end
            tick();
        end
        n_checks++;
        if (rise - e0 !== 2) begin
            n_fail++;
            $display("FAIL l1_latency: got %0d cycles required 2", rise - e0);
        end
        n_checks++;
        if ({l1_resp_write, l1_resp_addr, l1_resp_data} !== {1'b0, 5'h03, 8'h00}) begin
            n_fail++;
            $display("FAIL l1_fields: got w=%b a=%h d=%h required 0 03 00", l1_resp_write, l1_resp_addr, l1_resp_data);
        end
        repeat (3) tick();
        n_checks++;
        if (l1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL l1_idle: got busy=%b required 0", l1_busy);
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write_read();
        test_backpressure();
        test_fifo_wrap();
        test_reset_mid();
        test_latency_one();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
